// File: rtl/rob_core.sv
// rtl/rob_core.sv - in-order retirement reorder buffer tracking rename allocations
// Entries retire strictly from head once written back; old physical registers are returned at retire.
module rob_core #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alloc_valid,
    input  logic                       alloc_has_rd,
    input  logic [5:0]                 alloc_phys_rd,
    input  logic [5:0]                 alloc_old_phys_rd,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_rob_tag,
    input  logic                       wb_valid,
    input  logic [$clog2(DEPTH)-1:0]   wb_rob_tag,
    output logic                       retire_valid,
    output logic [5:0]                 retire_phys_reg,
    output logic                       retire_commit,
    output logic [$clog2(DEPTH):0]     rob_count
);
    localparam int TW = $clog2(DEPTH);
    localparam logic [TW:0] FULL_COUNT = DEPTH[TW:0];

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_has_rd;
    logic [DEPTH-1:0][5:0] ent_phys_rd;
    logic [DEPTH-1:0][5:0] ent_old_phys_rd;
    logic [TW-1:0]         head;
    logic [TW-1:0]         tail;

    logic alloc_fire;
    logic retire_fire;
    logic wb_fire;

    assign alloc_ready   = (rob_count != FULL_COUNT);
    assign alloc_rob_tag = tail;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign retire_fire   = ent_valid[head] && ent_done[head];
    // Only entries valid before the edge accept writeback, so a tag being allocated this cycle is ignored.
    assign wb_fire       = wb_valid && ent_valid[wb_rob_tag];

    // Physical destination travels with the entry for recovery; nothing downstream reads it yet.
    logic unused_phys_rd;
    assign unused_phys_rd = ^ent_phys_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head            <= '0;
            tail            <= '0;
            rob_count       <= '0;
            ent_valid       <= '0;
            ent_done        <= '0;
            retire_commit   <= 1'b0;
            retire_valid    <= 1'b0;
            retire_phys_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (retire_fire) begin
                head <= head + 1'b1;
            end
            rob_count <= rob_count + (TW+1)'(alloc_fire) - (TW+1)'(retire_fire);

            if (wb_fire) begin
                ent_done[wb_rob_tag] <= 1'b1;
            end
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
            end
            // Allocation and retirement never share an index: that would need a full buffer, which refuses allocation.
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end

            retire_commit   <= retire_fire;
            retire_valid    <= retire_fire && ent_has_rd[head];
            retire_phys_reg <= (retire_fire && ent_has_rd[head]) ? ent_old_phys_rd[head] : 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_has_rd[tail]      <= alloc_has_rd;
            ent_phys_rd[tail]     <= alloc_phys_rd;
            ent_old_phys_rd[tail] <= alloc_old_phys_rd;
        end
    end
endmodule

// File: tb/tb_rob_core.sv
// tb/tb_rob_core.sv - scoreboard bench for rob_core
module tb_rob_core;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       alloc_valid;
    logic       alloc_has_rd;
    logic [5:0] alloc_phys_rd;
    logic [5:0] alloc_old_phys_rd;
    logic       alloc_ready;
    logic [3:0] alloc_rob_tag;
    logic       wb_valid;
    logic [3:0] wb_rob_tag;
    logic       retire_valid;
    logic [5:0] retire_phys_reg;
    logic       retire_commit;
    logic [4:0] rob_count;

    rob_core #(.DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd),
        .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys_rd(alloc_old_phys_rd),
        .alloc_ready(alloc_ready), .alloc_rob_tag(alloc_rob_tag),
        .wb_valid(wb_valid), .wb_rob_tag(wb_rob_tag),
        .retire_valid(retire_valid), .retire_phys_reg(retire_phys_reg),
        .retire_commit(retire_commit), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [6:0] sb_q[$];
    logic [3:0] model_tail;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && retire_commit) begin
            if (sb_q.size() == 0) begin
                check("spurious_commit", 1, 0);
            end else begin
                logic [6:0] e;
                e = sb_q.pop_front();
                check("retire_valid", int'(retire_valid), int'(e[6]));
                check("retire_phys", int'(retire_phys_reg), int'(e[5:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_alloc(input logic has_rd, input logic [5:0] phys, input logic [5:0] old);
        check("alloc_tag", int'(alloc_rob_tag), int'(model_tail));
        alloc_valid = 1'b1;
        alloc_has_rd = has_rd;
        alloc_phys_rd = phys;
        alloc_old_phys_rd = old;
        if (alloc_ready) begin
            sb_q.push_back({has_rd, has_rd ? old : 6'd0});
            model_tail = model_tail + 4'd1;
        end
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] tag);
        wb_valid = 1'b1;
        wb_rob_tag = tag;
        cyc();
        wb_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) cyc();
        check("drain_left", sb_q.size(), 0);
        check("drain_count", int'(rob_count), 0);
    endtask

    initial begin
        logic [3:0] base;
        logic [3:0] prev;
        reset_n = 1'b0;
        alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_phys_rd = '0; alloc_old_phys_rd = '0;
        wb_valid = 1'b0; wb_rob_tag = '0;
        model_tail = '0;
        cyc(); cyc();
        check("rst_ready", int'(alloc_ready), 1);
        check("rst_tag", int'(alloc_rob_tag), 0);
        check("rst_count", int'(rob_count), 0);
        check("rst_commit", int'(retire_commit), 0);
        reset_n = 1'b1;
        cyc();
        check("post_rst_count", int'(rob_count), 0);

        // single instruction, minimum latency
        do_alloc(1'b1, 6'd40, 6'd5);
        check("single_count", int'(rob_count), 1);
        do_wb(4'd0);
        check("single_commit_early", int'(retire_commit), 0);
        cyc();
        check("single_commit", int'(retire_commit), 1);
        check("single_valid", int'(retire_valid), 1);
        check("single_phys", int'(retire_phys_reg), 5);
        cyc();
        check("single_commit_pulse", int'(retire_commit), 0);
        check("single_count_end", int'(rob_count), 0);

        // out-of-order completion
        base = model_tail;
        for (int k = 0; k < 3; k++) do_alloc(1'b1, 6'(30 + k), 6'(11 + k));
        do_wb(base + 4'd2);
        do_wb(base + 4'd1);
        check("ooo_no_retire", int'(retire_commit), 0);
        do_wb(base);
        check("ooo_wait", int'(retire_commit), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("ooo_commit", int'(retire_commit), 1);
        end
        cyc();
        check("ooo_commit_end", int'(retire_commit), 0);
        drain();

        // instruction without destination
        base = model_tail;
        do_alloc(1'b0, 6'd50, 6'd9);
        do_wb(base);
        cyc();
        check("nord_commit", int'(retire_commit), 1);
        drain();

        // fill to capacity, then refuse while head retires
        base = model_tail;
        for (int k = 0; k < 16; k++) do_alloc(1'b1, 6'(k), 6'(k + 20));
        check("full_count", int'(rob_count), 16);
        check("full_ready", int'(alloc_ready), 0);
        alloc_valid = 1'b1;
        cyc();
        check("full_drop_tag", int'(alloc_rob_tag), int'(base));
        check("full_drop_count", int'(rob_count), 16);
        wb_valid = 1'b1;
        wb_rob_tag = base;
        cyc();
        wb_valid = 1'b0;
        check("full_wb_ready", int'(alloc_ready), 0);
        cyc();
        alloc_valid = 1'b0;
        check("full_retire_count", int'(rob_count), 15);
        check("full_retire_ready", int'(alloc_ready), 1);
        check("full_retire_tag", int'(alloc_rob_tag), int'(base));
        for (int k = 1; k < 16; k++) do_wb(base + 4'(k));
        drain();

        // continuous stream wrapping the tags
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            check("wrap_tag", int'(alloc_rob_tag), int'(model_tail));
            alloc_valid = 1'b1;
            alloc_has_rd = 1'b1;
            alloc_phys_rd = 6'(i);
            alloc_old_phys_rd = 6'((i * 7 + 3) % 64);
            wb_valid = (i > 0);
            wb_rob_tag = prev;
            prev = alloc_rob_tag;
            if (alloc_ready) begin
                sb_q.push_back({1'b1, alloc_old_phys_rd});
                model_tail = model_tail + 4'd1;
            end
            cyc();
            check("wrap_count_bound", int'(rob_count <= 5'd16), 1);
        end
        alloc_valid = 1'b0;
        do_wb(prev);
        drain();

        // reset in the middle of activity
        base = model_tail;
        for (int k = 0; k < 5; k++) do_alloc(1'b1, 6'(k), 6'(20 + k));
        do_wb(base + 4'd1);
        do_wb(base + 4'd2);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_count", int'(rob_count), 0);
        check("midrst_ready", int'(alloc_ready), 1);
        check("midrst_tag", int'(alloc_rob_tag), 0);
        check("midrst_commit", int'(retire_commit), 0);
        check("midrst_valid", int'(retire_valid), 0);
        check("midrst_phys", int'(retire_phys_reg), 0);
        sb_q.delete();
        model_tail = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("postrst_quiet", int'(retire_commit), 0);
        end
        check("postrst_tag", int'(alloc_rob_tag), 0);
        do_alloc(1'b1, 6'd1, 6'd33);
        do_wb(4'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
